// File: rtl/bus_targets_pkg.sv
// Shared definitions for the CPU bus decoder/responder pair.
// Holds the fixed decoder target ordering, the default set of handshake
// targets, the responder state encoding and the responder counter widths.
package bus_targets_pkg;

  // Decoder target indices; the address decoder uses the same ordering.
  localparam int unsigned RAM        = 0;
  localparam int unsigned VDP        = 1;
  localparam int unsigned STATUS     = 2;
  localparam int unsigned DSP        = 3;
  localparam int unsigned PAD        = 4;
  localparam int unsigned COP_RAM    = 5;
  localparam int unsigned BOOTLOADER = 6;
  localparam int unsigned FLASH      = 7;

  localparam int unsigned NUM_TARGETS = 8;
  localparam int unsigned DATA_W      = 32;

  // Flash, dsp and vdp drive their own ready; everything else is fixed-wait.
  localparam logic [NUM_TARGETS-1:0] DEFAULT_HANDSHAKE_MASK = 8'b1000_1010;

  localparam int unsigned WAIT_CNT_W = 4;
  localparam int unsigned TMO_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FIXED = 2'd1,
    ST_WAIT_HS    = 2'd2,
    ST_ACK        = 2'd3
  } state_t;

endpackage

// File: rtl/cpu_bus_responder_if.sv
// Decoder-side bus bundle seen by the CPU bus responder.
//   target_sel    : one-hot target enables from the address decoder
//   target_rdata  : packed per-target read data, target i at [32*i +: 32]
//   target_ready  : per-target ready pulses (handshake targets only)
//   cpu_mem_ready : one-cycle acknowledge to the CPU
//   cpu_rdata     : read data returned with the acknowledge
//   bus_error     : sticky error flag
//   busy          : responder is not idle
// master = decoder/targets side, slave = responder.
interface cpu_bus_responder_if #(
  parameter int unsigned NUM_TARGETS = bus_targets_pkg::NUM_TARGETS
);

  logic [NUM_TARGETS-1:0]    target_sel;
  logic [32*NUM_TARGETS-1:0] target_rdata;
  logic [NUM_TARGETS-1:0]    target_ready;
  logic                      cpu_mem_ready;
  logic [31:0]               cpu_rdata;
  logic                      bus_error;
  logic                      busy;

  modport master (
    output target_sel,
    output target_rdata,
    output target_ready,
    input  cpu_mem_ready,
    input  cpu_rdata,
    input  bus_error,
    input  busy
  );

  modport slave (
    input  target_sel,
    input  target_rdata,
    input  target_ready,
    output cpu_mem_ready,
    output cpu_rdata,
    output bus_error,
    output busy
  );

endinterface

// File: rtl/bus_wait_timer.sv
// Wait-state and watchdog counters for the CPU bus responder.
//   clk, reset : clock and synchronous active-low reset
//   load       : load the wait down-counter with load_val
//   dec        : decrement the wait down-counter (stops at zero)
//   clr        : clear the watchdog up-counter
//   inc        : increment the watchdog up-counter (saturates, never wraps)
//   done       : wait down-counter is zero
//   expired    : watchdog up-counter has reached TIMEOUT_CYCLES-1
module bus_wait_timer
  import bus_targets_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WAIT_CNT_W-1:0] load_val,
  input  logic                  dec,
  input  logic                  clr,
  input  logic                  inc,
  output logic                  done,
  output logic                  expired
);

  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [TMO_CNT_W-1:0]  tmo_cnt;

  // Both counters; load/clear take priority over counting.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      if (load) begin
        wait_cnt <= load_val;
      end else if (dec && (wait_cnt != '0)) begin
        wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
      end

      if (clr) begin
        tmo_cnt <= '0;
      end else if (inc && (tmo_cnt != '1)) begin
        tmo_cnt <= tmo_cnt + TMO_CNT_W'(1);
      end
    end
  end

  assign done    = (wait_cnt == '0);
  assign expired = (tmo_cnt == TMO_LAST);

endmodule

// File: rtl/cpu_bus_responder.sv
// CPU bus responder: turns the decoder's one-hot target enables and the
// targets' read data / ready signals into a single registered
// cpu_mem_ready / cpu_rdata response. Fixed-wait targets are acknowledged
// after FIXED_WAIT cycles; handshake targets are waited on under a watchdog
// that forces an ERROR_RDATA acknowledge if ready never arrives.
//   clk   : system clock
//   reset : synchronous active-low reset
//   bus   : decoder/target bundle (slave modport), see cpu_bus_responder_if
module cpu_bus_responder #(
  parameter int unsigned             NUM_TARGETS    = bus_targets_pkg::NUM_TARGETS,
  parameter logic [NUM_TARGETS-1:0]  HANDSHAKE_MASK = bus_targets_pkg::DEFAULT_HANDSHAKE_MASK,
  parameter int unsigned             FIXED_WAIT     = 1,
  parameter int unsigned             TIMEOUT_CYCLES = 255,
  parameter logic [31:0]             ERROR_RDATA    = 32'hDEAD_BEEF
) (
  input  logic               clk,
  input  logic               reset,
  cpu_bus_responder_if.slave bus
);

  import bus_targets_pkg::state_t;
  import bus_targets_pkg::ST_IDLE;
  import bus_targets_pkg::ST_WAIT_FIXED;
  import bus_targets_pkg::ST_WAIT_HS;
  import bus_targets_pkg::ST_ACK;
  import bus_targets_pkg::WAIT_CNT_W;

  localparam int unsigned IDX_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
  localparam logic [WAIT_CNT_W-1:0] FIXED_LOAD =
    (FIXED_WAIT > 0) ? WAIT_CNT_W'(FIXED_WAIT - 1) : '0;

  state_t           state;
  logic [IDX_W-1:0] cur_idx;
  logic             mem_ready_q;
  logic [31:0]      rdata_q;
  logic             bus_error_q;
  logic             busy_q;

  logic             sel_any;
  logic             sel_multi;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_hs;
  logic             cur_ready;
  logic [IDX_W-1:0] mux_idx;
  logic [31:0]      rdata_arr [NUM_TARGETS];
  logic [31:0]      mux_rdata;

  logic             tmr_load;
  logic             tmr_dec;
  logic             tmr_clr;
  logic             tmr_inc;
  logic             tmr_done;
  logic             tmr_expired;

  // Request decode, read-data mux and timer controls.
  always_comb begin
    sel_any   = |bus.target_sel;
    sel_multi = ($countones(bus.target_sel) > 1);

    // Lowest set index wins when the decoder presents several enables.
    sel_idx = '0;
    for (int i = int'(NUM_TARGETS) - 1; i >= 0; i--) begin
      if (bus.target_sel[i]) begin
        sel_idx = IDX_W'(i);
      end
    end

    sel_hs    = HANDSHAKE_MASK[sel_idx];
    cur_ready = bus.target_ready[cur_idx] & HANDSHAKE_MASK[cur_idx];

    // Zero-wait fixed targets are captured straight out of IDLE.
    mux_idx = (state == ST_IDLE) ? sel_idx : cur_idx;
    for (int i = 0; i < int'(NUM_TARGETS); i++) begin
      rdata_arr[i] = bus.target_rdata[32*i +: 32];
    end
    mux_rdata = rdata_arr[mux_idx];

    tmr_load = (state == ST_IDLE) && sel_any && !sel_hs;
    tmr_clr  = (state == ST_IDLE);
    tmr_dec  = (state == ST_WAIT_FIXED);
    tmr_inc  = (state == ST_WAIT_HS) && !cur_ready;
  end

  bus_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .load_val(FIXED_LOAD),
    .dec     (tmr_dec),
    .clr     (tmr_clr),
    .inc     (tmr_inc),
    .done    (tmr_done),
    .expired (tmr_expired)
  );

  // Responder FSM with registered outputs; cpu_rdata only moves at capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cur_idx     <= '0;
      mem_ready_q <= 1'b0;
      rdata_q     <= '0;
      bus_error_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      mem_ready_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sel_any) begin
            cur_idx <= sel_idx;
            busy_q  <= 1'b1;
            if (sel_multi) begin
              bus_error_q <= 1'b1;
            end
            if (sel_hs) begin
              state <= ST_WAIT_HS;
            end else if (FIXED_WAIT == 0) begin
              rdata_q     <= mux_rdata;
              mem_ready_q <= 1'b1;
              state       <= ST_ACK;
            end else begin
              state <= ST_WAIT_FIXED;
            end
          end
        end

        ST_WAIT_FIXED: begin
          if (tmr_done) begin
            rdata_q     <= mux_rdata;
            mem_ready_q <= 1'b1;
            state       <= ST_ACK;
          end
        end

        // Ready takes priority over expiry on the same cycle.
        ST_WAIT_HS: begin
          if (cur_ready) begin
            rdata_q     <= mux_rdata;
            mem_ready_q <= 1'b1;
            state       <= ST_ACK;
          end else if (tmr_expired) begin
            rdata_q     <= ERROR_RDATA;
            bus_error_q <= 1'b1;
            mem_ready_q <= 1'b1;
            state       <= ST_ACK;
          end
        end

        // Enables still show the finished request here, so they are ignored.
        ST_ACK: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end

        default: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_mem_ready = mem_ready_q;
  assign bus.cpu_rdata     = rdata_q;
  assign bus.bus_error     = bus_error_q;
  assign bus.busy          = busy_q;

endmodule
